mux3x1: RTL and testbench
=========================

# mux3x1

Registered three-way word selector for the datapath operand/forwarding network. It picks one of three WIDTH-bit inputs (`in_a`, `in_b`, `in_c`) under a 2-bit select code and presents the chosen word on a registered output. The output register has an enable, a valid flag and an asynchronous active-low reset. The combinational select logic is also exported as a sub-module so other stages can use it unregistered.

## Interface
- `WIDTH`, default 32: data word width; must be at least 1.
- `RESET_VALUE`, default 0: value of `out` while reset is asserted.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_a` input, WIDTH bits: candidate word 0.
- `in_b` input, WIDTH bits: candidate word 1.
- `in_c` input, WIDTH bits: candidate word 2.
- `sel` input, 2 bits: select code.
- `en` input, 1 bit: capture enable for the output register.
- `out` output, WIDTH bits: registered selected word.
- `out_valid` output, 1 bit: high when `out` holds a word captured since reset.
- `sel_mux` output, WIDTH bits: combinational selected word (unregistered).

## Operation
- Decode of `sel`:
  - `2'b00` selects `in_a`.
  - `2'b01` selects `in_b`.
  - `2'b10` selects `in_c`.
  - `2'b11` selects `in_c`. This is a legal alias, not an error, so any code with bit 1 set selects `in_c`.
- `sel_mux` always equals the decoded word. It is a pure function of the current `sel`, `in_a`, `in_b` and `in_c`.
- `sel_mux` has no X-propagation requirement beyond normal RTL semantics. If `sel` is X/Z, the content of `out` is don't-care.
- When `en`=1 at a rising edge: `out` takes `sel_mux` and `out_valid` is set to 1.
- When `en`=0 at a rising edge: `out` and `out_valid` hold.
- No arithmetic is performed; all data paths are exactly WIDTH bits. There is no truncation or extension.

## Timing
- Reset:
  - While `rst_n`=0, `out`=`RESET_VALUE` and `out_valid`=0, regardless of `clk`.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Deassertion is synchronous-safe: the first capture happens on the first rising edge with `rst_n`=1 and `en`=1.
- Reset mid-operation discards the held word and clears `out_valid`. The first post-reset capture must then set `out_valid` again.
- Latency:
  - `sel_mux`: 0 cycles (combinational).
  - `out`: 1 cycle after the enabled edge.
- `sel` and data changing every cycle are supported. Each enabled edge samples the values present at that edge only.
- `en` held at 1 gives a new word every cycle. There is no backpressure or handshake beyond `en`.
- Simultaneous `sel` change and `en`=1 at the same edge: the register captures the word for the `sel` value sampled at that edge.

## Structure
- Shared package `mux_pkg` holds the select constants `SEL_A`=2'd0, `SEL_B`=2'd1, `SEL_C`=2'd2 and `SEL_C_ALT`=2'd3, plus a `sel_t` 2-bit typedef.
- Sub-module `mux3_comb` is parameterised by WIDTH and implements the purely combinational decode that drives `sel_mux`. The top level instantiates `mux3_comb` and adds the enable register, the valid flag and reset.

## Test plan
- Reset: hold `rst_n`=0 with `en`=1, `sel`=0 and `in_a`=32'hFFFF_FFFF. Required: `out`=0 and `out_valid`=0 throughout. After release and one edge: `out`=32'hFFFF_FFFF and `out_valid`=1.
- Sweep: for i=0..15 drive `in_a`=i and `in_b`=15−i, with `in_c`=32'hDEAD_BEEF. Step `sel` 0, 1, 2, 3 with `en`=1. Required on the following cycle: `out`=i, 15−i, 32'hDEAD_BEEF, 32'hDEAD_BEEF. `sel_mux` must show the same words in the same cycle.
- Enable hold: capture `in_b`=5 with `sel`=1, then drop `en` and change `in_b` to 9 and `sel` to 2. Required: `out` stays 5 and `out_valid` stays 1.
- Async reset mid-run: with `out`=7 and `out_valid`=1, pulse `rst_n` low between clock edges. Required: `out`=0 and `out_valid`=0 immediately, without a clock edge.
- Back-to-back: with `en`=1, change `sel` every cycle through 0, 2, 1, 3 with distinct constant inputs. Required: `out` follows the same sequence delayed by exactly one cycle.
- Width: instantiate with WIDTH=8 and RESET_VALUE=8'hA5. Required: reset gives `out`=8'hA5. With `sel`=2 and `in_c`=8'h3C, one edge later `out`=8'h3C.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared select encoding for the three-way operand/forwarding selectors.
// Both upper codes select in_c; code 3 is a legal alias rather than an error.
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A     = 2'd0;
    localparam sel_t SEL_B     = 2'd1;
    localparam sel_t SEL_C     = 2'd2;
    localparam sel_t SEL_C_ALT = 2'd3;

endpackage

// File: rtl/mux3_comb.sv
// Purely combinational three-way word selector.
// Exported on its own so other stages can use the selection unregistered.
module mux3_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  sel_t             sel,
    output logic [WIDTH-1:0] sel_mux
);

    always_comb begin
        sel_mux = in_c;
        case (sel)
            SEL_A:            sel_mux = in_a;
            SEL_B:            sel_mux = in_b;
            SEL_C, SEL_C_ALT: sel_mux = in_c;
            default:          sel_mux = in_c;
        endcase
    end

endmodule

// File: rtl/mux3x1.sv
// Registered three-way word selector with capture enable and valid flag.
// The unregistered selection is also exported as sel_mux.
module mux3x1
    import mux_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  sel_t             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] sel_mux
);

    mux3_comb #(
        .WIDTH (WIDTH)
    ) u_mux3_comb (
        .in_a    (in_a),
        .in_b    (in_b),
        .in_c    (in_c),
        .sel     (sel),
        .sel_mux (sel_mux)
    );

    // Reset drops both the held word and the valid flag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= RESET_VALUE;
            out_valid <= 1'b0;
        end else if (en) begin
            out       <= sel_mux;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux3x1.sv
// Self-checking bench for mux3x1: reference model plus directed and random stimulus.
// Runs a default 32-bit instance and an 8-bit instance with a non-zero reset value.
module tb_mux3x1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in_a  = '0;
    logic [31:0] in_b  = '0;
    logic [31:0] in_c  = '0;
    logic [1:0]  sel   = '0;
    logic        en    = 1'b0;

    logic [31:0] out32;
    logic        valid32;
    logic [31:0] mux32;
    logic [7:0]  out8;
    logic        valid8;
    logic [7:0]  mux8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux3x1 dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .sel       (sel),
        .en        (en),
        .out       (out32),
        .out_valid (valid32),
        .sel_mux   (mux32)
    );

    mux3x1 #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_a      (in_a[7:0]),
        .in_b      (in_b[7:0]),
        .in_c      (in_c[7:0]),
        .sel       (sel),
        .en        (en),
        .out       (out8),
        .out_valid (valid8),
        .sel_mux   (mux8)
    );

    // Reference selection: candidates in an array, codes above 2 clamp to in_c.
    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [1:0] s);
        logic [31:0] words [3];
        int idx;
        words[0] = a;
        words[1] = b;
        words[2] = c;
        idx = int'(s);
        if (idx > 2) idx = 2;
        return words[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: what each register must hold given every edge and reset seen so far.
    logic [31:0] exp_out32   = '0;
    logic        exp_valid   = 1'b0;
    logic [7:0]  exp_out8    = 8'hA5;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] w;
        if (!rst_n) begin
            exp_out32 = '0;
            exp_out8  = 8'hA5;
            exp_valid = 1'b0;
        end else if (en) begin
            w         = pick(in_a, in_b, in_c, sel);
            exp_out32 = w;
            exp_out8  = w[7:0];
            exp_valid = 1'b1;
        end
    end

    bit model_live = 1'b0;

    always @(negedge clk) begin
        logic [31:0] w;
        if (model_live) begin
            w = pick(in_a, in_b, in_c, sel);
            check("model out32",   out32,          exp_out32);
            check("model valid32", 32'(valid32),   32'(exp_valid));
            check("model mux32",   mux32,          w);
            check("model out8",    32'(out8),      32'(exp_out8));
            check("model valid8",  32'(valid8),    32'(exp_valid));
            check("model mux8",    32'(mux8),      32'(w[7:0]));
        end
    end

    // Land 1 ns after the next rising edge; inputs are then driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seq_exp [4];
        logic [1:0]  seq_sel [4];

        // Reset held with a capturable word pending.
        #1 rst_n = 1'b0;
        en   = 1'b1;
        sel  = 2'd0;
        in_a = 32'hFFFF_FFFF;
        model_live = 1'b1;
        repeat (3) tick();
        check("reset out",    out32,        32'h0);
        check("reset valid",  32'(valid32), 32'h0);
        check("reset out8",   32'(out8),    32'hA5);
        #1 rst_n = 1'b1;
        tick();
        check("first capture out",   out32,        32'hFFFF_FFFF);
        check("first capture valid", 32'(valid32), 32'h1);

        // Sweep every select code over a range of data words.
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 4; s++) begin
                #1;
                in_a = 32'(i);
                in_b = 32'(15 - i);
                in_c = 32'hDEAD_BEEF;
                sel  = 2'(s);
                #1;
                seq_exp[0] = 32'(i);
                seq_exp[1] = 32'(15 - i);
                seq_exp[2] = 32'hDEAD_BEEF;
                seq_exp[3] = 32'hDEAD_BEEF;
                check("sweep sel_mux", mux32, seq_exp[s]);
                tick();
                check("sweep out", out32, seq_exp[s]);
            end
        end

        // Enable low must hold the captured word.
        #1 sel = 2'd1; in_b = 32'd5; en = 1'b1;
        tick();
        check("hold capture", out32, 32'd5);
        #1 en = 1'b0; in_b = 32'd9; sel = 2'd2;
        tick();
        tick();
        check("hold out",   out32,        32'd5);
        check("hold valid", 32'(valid32), 32'h1);

        // Asynchronous reset between edges.
        #1 en = 1'b1; sel = 2'd0; in_a = 32'd7;
        tick();
        check("pre-reset out", out32, 32'd7);
        #1 rst_n = 1'b0;
        #1;
        check("async reset out",   out32,        32'h0);
        check("async reset valid", 32'(valid32), 32'h0);
        check("async reset out8",  32'(out8),    32'hA5);
        tick();
        #1 rst_n = 1'b1;
        tick();
        check("post-reset valid", 32'(valid32), 32'h1);
        check("post-reset out",   out32,        32'd7);

        // Back-to-back select changes, one capture per cycle.
        #1 in_a = 32'd11; in_b = 32'd22; in_c = 32'd33; en = 1'b1;
        seq_sel[0] = 2'd0; seq_exp[0] = 32'd11;
        seq_sel[1] = 2'd2; seq_exp[1] = 32'd33;
        seq_sel[2] = 2'd1; seq_exp[2] = 32'd22;
        seq_sel[3] = 2'd3; seq_exp[3] = 32'd33;
        for (int k = 0; k < 4; k++) begin
            sel = seq_sel[k];
            tick();
            check("b2b out", out32, seq_exp[k]);
            #1;
        end

        // Narrow instance capture.
        sel = 2'd2; in_c = 32'h0000_003C;
        tick();
        check("width8 out", 32'(out8), 32'h3C);

        // Random traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            #1;
            in_a = $urandom;
            in_b = $urandom;
            in_c = $urandom;
            sel  = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        @(negedge clk);
        model_live = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
